mem_stage: RTL and testbench

- MEM pipeline stage; sits between the EX/MEM pipeline register and the MEM/WB register.
- Consumes the load/store request held by EX/MEM and performs it as a sequence of byte transactions with the memory controller.
- Assembles and sign- or zero-extends load data, and raises a stall request until the access completes.
- Non-memory instructions pass straight through with no stall.

---
 rtl/mem_stage.sv | 200 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : MEM pipeline stage. Breaks the load/store held in EX/MEM into
//            byte transactions with the memory controller. Load bytes are
//            assembled little-endian, then sign- or zero-extended. A stall
//            is requested until the access completes. Non-memory
//            instructions pass straight through.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   rdy                 global ready; 0 freezes all state
//   wd_i, wreg_i,
//   wdata_i             write-back fields from EX/MEM
//   load_i, store_i     memory request (store wins when both are set)
//   mem_addr_i          byte address of the access
//   mem_write_data_i    store data
//   mem_length_i        access length in bytes (1/2/4; others remapped)
//   mem_signed_i        sign-extend load data when 1
//   wb_hold_i           MEM/WB frozen this cycle
//   mem_ack_i,
//   mem_din_i           byte handshake and read data from the controller
//   wd_o, wreg_o,
//   wdata_o             write-back fields to MEM/WB
//   stall_req_o         freeze request for stages up to EX/MEM
//   mem_req_o, mem_we_o,
//   mem_a_o, mem_dout_o byte request to the memory controller
// ============================================================================
module mem_stage #(
  parameter int ADDR_W = 32,
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [ADDR_W-1:0] wdata_i,
  input  logic              load_i,
  input  logic              store_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [ADDR_W-1:0] mem_write_data_i,
  input  logic [2:0]        mem_length_i,
  input  logic              mem_signed_i,
  input  logic              wb_hold_i,
  input  logic              mem_ack_i,
  input  logic [BYTE_W-1:0] mem_din_i,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [ADDR_W-1:0] wdata_o,
  output logic              stall_req_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic [BYTE_W-1:0] mem_dout_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state;
  logic [1:0]        cnt;
  logic [ADDR_W-1:0] ld_buf;

  logic              req_any;
  logic              is_load;
  logic [1:0]        last_idx;
  logic [BYTE_W-1:0] dout_sel;
  logic [ADDR_W-1:0] ld_ext;

  assign req_any = load_i | store_i;
  // A combined load+store behaves as a store: nothing is written back.
  assign is_load = load_i & ~store_i;

  // Index of the final byte. Length 0 behaves as a byte access; every other
  // unsupported length behaves as a word access.
  always_comb begin
    last_idx = 2'd3;
    case (mem_length_i)
      3'd0, 3'd1: last_idx = 2'd0;
      3'd2:       last_idx = 2'd1;
      default:    last_idx = 2'd3;
    endcase
  end

  // Store byte for the current index.
  always_comb begin
    dout_sel = '0;
    for (int i = 0; i < 4; i++) begin
      if (cnt == 2'(i)) begin
        dout_sel = mem_write_data_i[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Extension of the assembled load data. The length decode is reused, so
  // remapped lengths extend exactly as their legal equivalents.
  always_comb begin
    ld_ext = ld_buf;
    case (last_idx)
      2'd0:    ld_ext = {{(ADDR_W-BYTE_W){mem_signed_i & ld_buf[BYTE_W-1]}},
                         ld_buf[BYTE_W-1:0]};
      2'd1:    ld_ext = {{(ADDR_W-2*BYTE_W){mem_signed_i & ld_buf[2*BYTE_W-1]}},
                         ld_buf[2*BYTE_W-1:0]};
      default: ld_ext = ld_buf;
    endcase
  end

  // Outputs are decoded from the current state and the EX/MEM inputs so
  // that a new request stalls in the very cycle it is presented.
  always_comb begin
    wd_o        = wd_i;
    wreg_o      = wreg_i;
    wdata_o     = wdata_i;
    stall_req_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_a_o     = '0;
    mem_dout_o  = '0;
    case (state)
      S_IDLE: begin
        if (req_any) begin
          // The instruction has not completed yet; keep it out of MEM/WB.
          stall_req_o = 1'b1;
          wreg_o      = 1'b0;
        end
      end
      S_BUSY: begin
        stall_req_o = 1'b1;
        wreg_o      = 1'b0;
        // Address and data stay on the bus while rdy is low; only the
        // request strobe is withdrawn.
        mem_req_o   = rdy;
        mem_we_o    = store_i;
        mem_a_o     = mem_addr_i + {{(ADDR_W-2){1'b0}}, cnt};
        mem_dout_o  = dout_sel;
      end
      S_DONE: begin
        if (is_load) begin
          wdata_o = ld_ext;
        end
      end
      default: begin
        stall_req_o = 1'b0;
      end
    endcase
  end

  // Reset has priority over rdy, so an access aborts even while frozen.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      cnt    <= 2'd0;
      ld_buf <= '0;
    end else if (rdy) begin
      case (state)
        S_IDLE: begin
          if (req_any) begin
            state <= S_BUSY;
            cnt   <= 2'd0;
          end
        end
        S_BUSY: begin
          if (mem_ack_i) begin
            if (is_load) begin
              for (int i = 0; i < 4; i++) begin
                if (cnt == 2'(i)) begin
                  ld_buf[i*BYTE_W +: BYTE_W] <= mem_din_i;
                end
              end
            end
            if (cnt == last_idx) begin
              state <= S_DONE;
            end else begin
              cnt <= cnt + 2'd1;
            end
          end
        end
        S_DONE: begin
          // Remain here while MEM/WB is frozen so the result is not lost;
          // no new memory request is raised from this state.
          if (!wb_hold_i) begin
            state  <= S_IDLE;
            cnt    <= 2'd0;
            ld_buf <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
`default_nettype none
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic        load_i, store_i;
  logic [31:0] mem_addr_i, mem_write_data_i;
  logic [2:0]  mem_length_i;
  logic        mem_signed_i, wb_hold_i, mem_ack_i;
  logic [7:0]  mem_din_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stall_req_o, mem_req_o, mem_we_o;
  logic [31:0] mem_a_o;
  logic [7:0]  mem_dout_o;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_W(32), .BYTE_W(8)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .load_i(load_i), .store_i(store_i),
    .mem_addr_i(mem_addr_i), .mem_write_data_i(mem_write_data_i),
    .mem_length_i(mem_length_i), .mem_signed_i(mem_signed_i),
    .wb_hold_i(wb_hold_i), .mem_ack_i(mem_ack_i), .mem_din_i(mem_din_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .stall_req_o(stall_req_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_a_o(mem_a_o), .mem_dout_o(mem_dout_o)
  );

  int tests = 0;
  int fails = 0;

  // Byte-addressed memory model, aliased on the low 8 address bits.
  logic [7:0] mem [256];
  // Scripted {rdy, ack} pairs for BUSY cycles.
  logic [1:0] sched [$];

  typedef struct {
    logic        ld;
    logic        st;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  len;
    logic        sgn;
    int          hold;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int eff_len(input logic [2:0] len);
    if (len == 3'd0 || len == 3'd1) return 1;
    if (len == 3'd2) return 2;
    return 4;
  endfunction

  // Load result from the memory model: little-endian value, then extension
  // by plain arithmetic.
  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] len,
                                             input logic sgn);
    int     n;
    longint v;
    logic [31:0] a;
    n = eff_len(len);
    v = 0;
    for (int k = 0; k < n; k++) begin
      a = addr + 32'(k);
      v = v + (longint'(mem[a[7:0]]) << (8 * k));
    end
    if (sgn && v >= (longint'(1) << (8 * n - 1)))
      v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic pass_thru(input logic [4:0] wd, input logic wr, input logic [31:0] alu,
                           input logic r);
    load_i = 0; store_i = 0; wd_i = wd; wreg_i = wr; wdata_i = alu;
    rdy = r; mem_ack_i = 0; wb_hold_i = 0;
    #1;
    chk("pt_wd", 32'(wd_o), 32'(wd));
    chk("pt_wreg", 32'(wreg_o), 32'(wr));
    chk("pt_wdata", wdata_o, alu);
    chk("pt_stall", 32'(stall_req_o), 0);
    chk("pt_req", 32'(mem_req_o), 0);
    tick;
  endtask

  // mode 0: ack every cycle; 1: random rdy/ack; 2: scripted from sched.
  task automatic run_op(input logic ld, input logic st, input logic [31:0] addr,
                        input logic [31:0] data, input logic [2:0] len, input logic sgn,
                        input logic [4:0] wd, input logic wr, input logic [31:0] alu,
                        input int hold, input int mode, input logic [31:0] exp_res);
    int n, k, guard, si;
    logic r, a;
    logic [31:0] ea, sh;
    n = eff_len(len);
    load_i = ld; store_i = st; mem_addr_i = addr; mem_write_data_i = data;
    mem_length_i = len; mem_signed_i = sgn; wd_i = wd; wreg_i = wr; wdata_i = alu;
    rdy = 1; mem_ack_i = 0; wb_hold_i = 0;
    #1;
    chk("idle_stall", 32'(stall_req_o), 1);
    chk("idle_req", 32'(mem_req_o), 0);
    tick;
    k = 0; guard = 0; si = 0;
    while (k < n && guard < 200) begin
      r = 1; a = 1;
      if (mode == 1) begin
        r = ($urandom_range(0, 4) != 0);
        a = ($urandom_range(0, 1) == 1);
      end else if (mode == 2 && si < sched.size()) begin
        r = sched[si][1];
        a = sched[si][0];
        si++;
      end
      ea = addr + 32'(k);
      sh = data >> (8 * k);
      rdy = r; mem_ack_i = a; mem_din_i = mem[ea[7:0]];
      #1;
      chk("busy_stall", 32'(stall_req_o), 1);
      chk("busy_req", 32'(mem_req_o), 32'(r));
      chk("busy_we", 32'(mem_we_o), 32'(st));
      chk("busy_addr", mem_a_o, ea);
      chk("busy_dout", 32'(mem_dout_o), 32'(sh[7:0]));
      chk("busy_wreg", 32'(wreg_o), 0);
      if (r && a) begin
        if (st) mem[ea[7:0]] = sh[7:0];
        k++;
      end
      guard++;
      tick;
    end
    if (k < n) begin
      tests++; fails++;
      $display("FAIL busy_timeout: got %0d bytes expected %0d", k, n);
    end
    rdy = 1; mem_ack_i = 0;
    for (int h = 0; h <= hold; h++) begin
      wb_hold_i = (h < hold);
      #1;
      chk("done_stall", 32'(stall_req_o), 0);
      chk("done_req", 32'(mem_req_o), 0);
      chk("done_wreg", 32'(wreg_o), 32'(wr));
      chk("done_wd", 32'(wd_o), 32'(wd));
      chk("done_wdata", wdata_o, exp_res);
      tick;
    end
    wb_hold_i = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res, addr, data, alu;
    logic [2:0]  len;
    logic [2:0]  lens [11];
    int op;

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h00] = 8'h80;
    mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;
    mem[8'h20] = 8'h9C;
    mem[8'h40] = 8'hFE; mem[8'h41] = 8'hFF;

    //           ld    st    addr           data           len   sgn  hold exp
    tbl[0]  = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,         3'd1, 1'b1, 0, 32'hFFFF_FF80};
    tbl[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         3'd4, 1'b0, 0, 32'h4433_2211};
    tbl[2]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         3'd1, 1'b0, 2, 32'h0000_009C};
    tbl[3]  = '{1'b0, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 3'd4, 1'b0, 0, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, 32'h0000_0200, 32'h0,         3'd4, 1'b0, 0, 32'hDEAD_BEEF};
    tbl[5]  = '{1'b1, 1'b0, 32'h0000_0202, 32'h0,         3'd2, 1'b1, 1, 32'hFFFF_DEAD};
    tbl[6]  = '{1'b1, 1'b0, 32'h0000_0202, 32'h0,         3'd2, 1'b0, 0, 32'h0000_DEAD};
    tbl[7]  = '{1'b1, 1'b0, 32'h0000_0203, 32'h0,         3'd1, 1'b0, 0, 32'h0000_00DE};
    tbl[8]  = '{1'b1, 1'b0, 32'h0000_0201, 32'h0,         3'd1, 1'b1, 0, 32'hFFFF_FFBE};
    tbl[9]  = '{1'b0, 1'b1, 32'h0000_0300, 32'h7F00_8001, 3'd4, 1'b0, 0, 32'h0};
    tbl[10] = '{1'b1, 1'b0, 32'h0000_0300, 32'h0,         3'd2, 1'b1, 0, 32'hFFFF_8001};
    tbl[11] = '{1'b1, 1'b0, 32'h0000_0300, 32'h0,         3'd0, 1'b1, 0, 32'h0000_0001};
    tbl[12] = '{1'b1, 1'b0, 32'h0000_0300, 32'h0,         3'd3, 1'b0, 0, 32'h7F00_8001};
    tbl[13] = '{1'b1, 1'b1, 32'h0000_0310, 32'hCAFE_F00D, 3'd4, 1'b0, 0, 32'h0};
    tbl[14] = '{1'b1, 1'b0, 32'h0000_0310, 32'h0,         3'd4, 1'b0, 0, 32'hCAFE_F00D};
    tbl[15] = '{1'b0, 1'b1, 32'hFFFF_FFFE, 32'hA1B2_C3D4, 3'd4, 1'b0, 0, 32'h0};
    tbl[16] = '{1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0,         3'd4, 1'b1, 0, 32'hA1B2_C3D4};
    tbl[17] = '{1'b1, 1'b0, 32'h0000_0300, 32'h0,         3'd6, 1'b0, 0, 32'h7F00_A1B2};
    tbl[18] = '{1'b0, 1'b1, 32'h0000_0400, 32'h1111_5AA5, 3'd2, 1'b0, 0, 32'h0};
    tbl[19] = '{1'b1, 1'b0, 32'h0000_0400, 32'h0,         3'd5, 1'b0, 0, 32'h7F00_5AA5};

    lens = '{3'd1, 3'd2, 3'd4, 3'd1, 3'd2, 3'd4, 3'd0, 3'd3, 3'd5, 3'd6, 3'd7};

    // Reset, including a pending request that must not start while in reset.
    rst = 0; rdy = 1; wd_i = 0; wreg_i = 0; wdata_i = 0; load_i = 0; store_i = 0;
    mem_addr_i = 0; mem_write_data_i = 0; mem_length_i = 0; mem_signed_i = 0;
    wb_hold_i = 0; mem_ack_i = 0; mem_din_i = 0;
    tick; tick; tick;
    rst = 1;
    #1;
    chk("rst_stall", 32'(stall_req_o), 0);
    chk("rst_req", 32'(mem_req_o), 0);
    chk("rst_wreg", 32'(wreg_o), 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_addr", mem_a_o, 0);
    tick;

    for (int i = 0; i < 3; i++) pass_thru(5'd5, 1'b1, 32'h1234, 1'b1);

    // Table vectors, issued back to back with zero-wait acks.
    for (int i = 0; i < 20; i++) begin
      alu = 32'hA000_0000 | 32'(i);
      res = (tbl[i].st || !tbl[i].ld) ? alu : tbl[i].exp;
      run_op(tbl[i].ld, tbl[i].st, tbl[i].addr, tbl[i].data, tbl[i].len, tbl[i].sgn,
             5'(i + 1), 1'b1, alu, tbl[i].hold, 0, res);
    end

    // Unsigned half load with waits and a rdy gap.
    sched = '{2'b11, 2'b10, 2'b01, 2'b00, 2'b10, 2'b11};
    run_op(1'b1, 1'b0, 32'h0000_0040, 32'h0, 3'd2, 1'b0, 5'd9, 1'b1, 32'h5555, 0, 2,
           32'h0000_FFFE);

    // Reset (together with rdy=0) after the first byte of a word load.
    load_i = 1; store_i = 0; mem_addr_i = 32'h80; mem_length_i = 3'd4; mem_signed_i = 0;
    wd_i = 5'd3; wreg_i = 1; wdata_i = 32'h77; rdy = 1; mem_ack_i = 0;
    tick;
    mem_ack_i = 1; mem_din_i = 8'h5B;
    tick;
    rst = 0; rdy = 0; mem_ack_i = 1;
    tick;
    rst = 1;
    res = model_load(32'h80, 3'd4, 1'b0);
    run_op(1'b1, 1'b0, 32'h80, 32'h0, 3'd4, 1'b0, 5'd3, 1'b1, 32'h77, 1, 0, res);

    // Randomised operations against the memory model.
    for (int it = 0; it < 60; it++) begin
      op   = $urandom_range(0, 9);
      addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                         : 32'($urandom);
      data = 32'($urandom);
      alu  = 32'($urandom);
      len  = lens[$urandom_range(0, 10)];
      if (op < 2) begin
        pass_thru(5'($urandom), 1'($urandom), alu, 1'($urandom));
      end else begin
        res = (op >= 2 && op <= 5) ? model_load(addr, len, 1'($urandom_range(0, 0))) : alu;
        if (op >= 2 && op <= 5) begin
          if ($urandom_range(0, 1) == 1) begin
            res = model_load(addr, len, 1'b1);
            run_op(1'b1, 1'b0, addr, data, len, 1'b1, 5'($urandom), 1'b1, alu,
                   $urandom_range(0, 2), 1, res);
          end else begin
            run_op(1'b1, 1'b0, addr, data, len, 1'b0, 5'($urandom), 1'b1, alu,
                   $urandom_range(0, 2), 1, res);
          end
        end else begin
          run_op(op == 9, 1'b1, addr, data, len, 1'($urandom), 5'($urandom), 1'b0, alu,
                 $urandom_range(0, 2), 1, res);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
